extend_pipe: RTL

Pipelined, parametrised immediate extender for the decode/execute boundary. It accepts the 24-bit instruction immediate field plus a mode select. It produces a WIDTH-bit immediate, including the ARM rotated data-processing immediate (imm8 ROR 2·rot) and its shifter carry-out. Two register stages with a valid/ready handshake, a flush input and an error flag for reserved modes let it sit directly in a stallable pipeline.

---
 rtl/extend_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/extend_pipe.sv
// rtl/extend_pipe.sv - two-stage immediate extender with valid/ready, flush and reserved-mode flag
module extend_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic             SignExtend,
  input  logic             CarryIn,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_imm,
  output logic             out_carry,
  output logic             out_err
);

  logic        s1_valid;
  logic        s2_valid;
  logic [31:0] s1_val;
  logic [4:0]  s1_rot;
  logic        s1_fill;
  logic        s1_cin;
  logic        s1_use_rot;
  logic        s1_err;

  logic        s2_adv;
  logic        s1_adv;
  logic        accept;

  logic [31:0] d_val;
  logic [4:0]  d_rot;
  logic        d_fill;
  logic        d_use_rot;
  logic        d_err;
  logic        d_sx;

  logic [31:0]      rot32;
  logic             rot_carry;
  logic [WIDTH-1:0] ext;

  assign s2_adv    = out_ready | ~s2_valid;
  assign s1_adv    = s1_valid & s2_adv;
  assign in_ready  = reset_n & ~flush & (~s1_valid | s1_adv);
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Stage 1 decode: every mode except 000 is fully formed in 32 bits here, rot stays 0
  always_comb begin
    d_val     = 32'd0;
    d_rot     = 5'd0;
    d_fill    = 1'b0;
    d_use_rot = 1'b0;
    d_err     = 1'b0;
    d_sx      = SignExtend & Instr[11];
    case (ImmSrc)
      3'b000: begin
        d_val     = {24'd0, Instr[7:0]};
        d_rot     = {Instr[11:8], 1'b0};
        d_use_rot = 1'b1;
      end
      3'b001: d_val = {20'd0, Instr[11:0]};
      3'b010: begin
        d_val  = {{20{d_sx}}, Instr[11:0]};
        d_fill = d_sx;
      end
      3'b011: begin
        d_val  = {{6{Instr[23]}}, Instr, 2'b00};
        d_fill = Instr[23];
      end
      3'b100: begin
        d_val  = {{24{d_sx}}, Instr[11:8], Instr[3:0]};
        d_fill = d_sx;
      end
      default: d_err = 1'b1;
    endcase
  end

  // A zero rotate shifts the left term by 32, which yields 0 and leaves s1_val intact
  assign rot32     = (s1_val >> s1_rot) | (s1_val << (6'd32 - {1'b0, s1_rot}));
  assign rot_carry = (s1_use_rot && s1_rot != 5'd0) ? rot32[31] : s1_cin;

  generate
    if (WIDTH > 32) begin : g_wide
      assign ext = {{(WIDTH-32){s1_fill}}, rot32};
    end else begin : g_narrow
      assign ext = rot32;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_val     <= 32'd0;
      s1_rot     <= 5'd0;
      s1_fill    <= 1'b0;
      s1_cin     <= 1'b0;
      s1_use_rot <= 1'b0;
      s1_err     <= 1'b0;
      out_imm    <= '0;
      out_carry  <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (flush)       s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;

      if (accept) begin
        s1_val     <= d_val;
        s1_rot     <= d_rot;
        s1_fill    <= d_fill;
        s1_cin     <= CarryIn;
        s1_use_rot <= d_use_rot;
        s1_err     <= d_err;
      end

      if (s1_adv && !flush) begin
        out_imm   <= ext;
        out_carry <= rot_carry;
        out_err   <= s1_err;
      end
    end
  end

endmodule
